// File: rtl/if_fetch_ctrl_pkg.sv
// Shared constants and types for the instruction-fetch controller.
package if_fetch_ctrl_pkg;

   localparam int PC_TO_IT_WD  = 65;   // {excepttype, ce, pc}
   localparam int IC_TO_ID_WD  = 97;   // {valid, excepttype, pc, inst}
   localparam int STALL_W      = 6;    // global stall vector, bit 1 holds IF/ID
   localparam int EXC_ADEL_BIT = 16;   // instruction-address error flag in excepttype

   localparam logic [1:0] INST_SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      IF_IDLE = 2'd0,
      IF_REQ  = 2'd1,
      IF_WAIT = 2'd2
   } if_state_e;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// SRAM-like instruction port: the fetch controller is master, memory is slave.
interface if_fetch_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();

   logic              inst_req;
   logic [ADDR_W-1:0] inst_addr;
   logic              inst_wr;
   logic [1:0]        inst_size;
   logic              inst_addr_ok;
   logic              inst_data_ok;
   logic [DATA_W-1:0] inst_rdata;

   modport master (
      output inst_req, inst_addr, inst_wr, inst_size,
      input  inst_addr_ok, inst_data_ok, inst_rdata
   );

   modport slave (
      input  inst_req, inst_addr, inst_wr, inst_size,
      output inst_addr_ok, inst_data_ok, inst_rdata
   );

endinterface

// File: rtl/if_fetch_ctrl_skid_buf.sv
// Single-entry holding register for a fetched word that arrives while decode is stalled.
module if_skid_buf #(
   parameter int WORD_W = 96
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              drain_i,
   input  logic              clear_i,
   input  logic [WORD_W-1:0] data_i,
   output logic              full_o,
   output logic [WORD_W-1:0] data_o
);

   logic              full_q;
   logic [WORD_W-1:0] data_q;

   // Clear wins over load; a drained entry only drops its full flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else if (clear_i) begin
         full_q <= 1'b0;
      end else if (load_i) begin
         full_q <= 1'b1;
         data_q <= data_i;
      end else if (drain_i) begin
         full_q <= 1'b0;
      end
   end

   assign full_o = full_q;
   assign data_o = data_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding read per PC, flush cancellation,
// and delivery to IF/ID through a one-entry skid buffer.
module if_fetch_ctrl
   import if_fetch_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int EXC_W  = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [EXC_W+ADDR_W:0]        pc_to_ic_bus_i,
   input  logic [STALL_W-1:0]           stall_i,
   input  logic                         flush_i,
   output logic                         stallreq_if_o,
   if_fetch_ctrl_if.master              imem,
   output logic [EXC_W+ADDR_W+DATA_W:0] ic_to_id_bus_o
);

   localparam int WORD_W = EXC_W + ADDR_W + DATA_W;

   logic [ADDR_W-1:0] pc_in;
   logic              ce_in;
   logic [EXC_W-1:0]  exc_in;
   logic              adel_in;
   logic              id_hold;
   logic              unused_stall;

   assign pc_in   = pc_to_ic_bus_i[ADDR_W-1:0];
   assign ce_in   = pc_to_ic_bus_i[ADDR_W];
   assign exc_in  = pc_to_ic_bus_i[EXC_W+ADDR_W:ADDR_W+1];
   assign adel_in = exc_in[EXC_ADEL_BIT];
   assign id_hold = stall_i[1];
   assign unused_stall = ^{stall_i[STALL_W-1:2], stall_i[0]};

   if_state_e         state_q, state_d;
   logic              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [EXC_W-1:0]  exc_q, exc_d;
   logic              cancel_q, cancel_d;
   logic [WORD_W:0]   out_q, out_d;

   logic              word_ok;     // uncancelled word returning this cycle
   logic              adel_ok;     // faulting PC presented without a bus read
   logic              skid_full;
   logic              skid_load;
   logic              skid_drain;
   logic [WORD_W-1:0] skid_data;

   if_skid_buf #(.WORD_W(WORD_W)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (skid_load),
      .drain_i (skid_drain),
      .clear_i (flush_i),
      .data_i  ({exc_q, pc_q, imem.inst_rdata}),
      .full_o  (skid_full),
      .data_o  (skid_data)
   );

   // Next-state logic: launch, hold the request until accepted, await data.
   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      addr_d   = addr_q;
      pc_d     = pc_q;
      exc_d    = exc_q;
      cancel_d = cancel_q;
      word_ok  = 1'b0;
      adel_ok  = 1'b0;
      unique case (state_q)
         IF_IDLE: begin
            // A pending skid entry must drain before anything new is fetched.
            if (ce_in && !flush_i && !skid_full) begin
               if (adel_in) begin
                  adel_ok = !id_hold;
               end else begin
                  state_d = IF_REQ;
                  req_d   = 1'b1;
                  addr_d  = pc_in;
                  pc_d    = pc_in;
                  exc_d   = exc_in;
               end
            end
         end
         IF_REQ: begin
            // The request is never withdrawn; a flush only marks it stale.
            if (flush_i) cancel_d = 1'b1;
            if (imem.inst_addr_ok) begin
               req_d   = 1'b0;
               state_d = IF_WAIT;
            end
         end
         IF_WAIT: begin
            if (imem.inst_data_ok) begin
               state_d  = IF_IDLE;
               cancel_d = 1'b0;
               word_ok  = !cancel_q && !flush_i;
            end else if (flush_i) begin
               cancel_d = 1'b1;
            end
         end
         default: state_d = IF_IDLE;
      endcase
   end

   // Hold the PC stage while its word is in flight or a buffered word blocks refetch.
   always_comb begin
      stallreq_if_o = 1'b0;
      unique case (state_q)
         IF_IDLE: stallreq_if_o = ce_in && skid_full;
         IF_REQ:  stallreq_if_o = 1'b1;
         IF_WAIT: stallreq_if_o = !word_ok;
         default: stallreq_if_o = 1'b0;
      endcase
   end

   // IF/ID output register: flush, hold, skid drain, new word, ADEL, then bubble.
   always_comb begin
      out_d      = out_q;
      skid_load  = 1'b0;
      skid_drain = 1'b0;
      if (flush_i) begin
         out_d = '0;
      end else if (id_hold) begin
         skid_load = word_ok;
      end else if (skid_full) begin
         out_d      = {1'b1, skid_data};
         skid_drain = 1'b1;
      end else if (word_ok) begin
         out_d = {1'b1, exc_q, pc_q, imem.inst_rdata};
      end else if (adel_ok) begin
         out_d = {1'b1, exc_in, pc_in, {DATA_W{1'b0}}};
      end else begin
         out_d = '0;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IF_IDLE;
         req_q    <= 1'b0;
         addr_q   <= '0;
         pc_q     <= '0;
         exc_q    <= '0;
         cancel_q <= 1'b0;
         out_q    <= '0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         addr_q   <= addr_d;
         pc_q     <= pc_d;
         exc_q    <= exc_d;
         cancel_q <= cancel_d;
         out_q    <= out_d;
      end
   end

   assign imem.inst_req   = req_q;
   assign imem.inst_addr  = addr_q;
   assign imem.inst_wr    = 1'b0;
   assign imem.inst_size  = INST_SIZE_WORD;
   assign ic_to_id_bus_o  = out_q;

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Instruction-fetch sequencer between the PC register stage and the SRAM-like instruction port. It takes the PC stage's {excepttype, ce, pc} bus and issues at most one outstanding read per PC. It raises an IF stall request while the word is in flight. On flush it cancels or drops stale returns, and it delivers {pc, inst, excepttype} to the IF/ID boundary through a one-entry skid buffer when the decode stage is stalled.

Parameters:
- ADDR_W, 32, fetch address width.
- DATA_W, 32, instruction word width.
- EXC_W, 32, exception-type field width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- pc_to_ic_bus  in  `PC_TO_IT_WD (65)  [64:33] excepttype, [32] ce, [31:0] pc.
- stall  in  `StallBus  global stall vector; stall[1] = IF/ID hold.
- flush  in  1  pipeline flush (exception/eret).
- stallreq_if  out  1  request to hold the PC stage (drives stall[0] via the stall controller).
- inst_req  out  1  SRAM-like request.
- inst_addr  out  ADDR_W  request address; inst_wr is tied 0, inst_size is tied 2'b10.
- inst_addr_ok  in  1  address accepted.
- inst_data_ok  in  1  read data valid.
- inst_rdata  in  DATA_W  read data.
- ic_to_id_bus  out  `IC_TO_ID_WD (97)  [96] valid, [95:64] excepttype, [63:32] pc, [31:0] inst.

Behaviour:
- Reset (rst=0, async) values: state=IDLE, inst_req=0, inst_addr=0, cancel=0, skid buffer empty, ic_to_id_bus all 0, stallreq_if=0.
- States: IDLE, REQ, WAIT.
- IDLE:
  - If ce=1, excepttype[16]=0, flush=0 and the skid buffer is empty: assert inst_req next cycle with inst_addr=pc, latch pc/excepttype, go to REQ.
  - If ce=1 and excepttype[16]=1 (ADEL): issue no bus request. Present valid=1, inst=0, pc, excepttype on the next non-stalled edge. Stay in IDLE.
- REQ:
  - inst_req and inst_addr are held stable until inst_addr_ok=1. On that cycle, deassert inst_req and go to WAIT.
  - A request is never withdrawn. A flush in REQ sets cancel=1.
- WAIT:
  - On inst_data_ok=1, go to IDLE. If cancel=1, drop the data and clear cancel. Otherwise deliver the word.
  - A flush in WAIT sets cancel=1.
- Same-cycle events:
  - addr_ok and data_ok in the same REQ cycle count as addr_ok only. Data is only sampled in WAIT.
  - Flush and data_ok in the same cycle: the data is dropped.
- stallreq_if:
  - =1 whenever state is REQ or WAIT and the latched PC's word has not returned uncancelled.
  - Combinationally =0 in the WAIT cycle where inst_data_ok=1 and cancel=0 and flush=0, so the PC advances that edge.
  - =1 in IDLE while the skid buffer is full and ce=1.
- Delivery and backpressure:
  - With stall[1]=0, the delivered word is registered into ic_to_id_bus at the edge following data_ok, with valid=1. Latency from data_ok to valid is 1 cycle.
  - If stall[1]=1 when the word arrives, it goes into the skid buffer and ic_to_id_bus holds its value.
  - The buffer drains into ic_to_id_bus on the first edge with stall[1]=0. That edge takes priority over new bus data, so no new request is issued while the buffer is full.
  - With stall[1]=0 and nothing to deliver, ic_to_id_bus.valid is registered as 0 (bubble).
- Flush:
  - Clears ic_to_id_bus.valid and the skid buffer at the same edge.
  - Returns REQ/WAIT states to their cancel path, not to IDLE directly; the protocol requires the outstanding transaction to complete.
- Outstanding limit: exactly one transaction; no pipelined requests.
- Reset mid-transaction: all state is cleared immediately. The external SRAM-like slave is reset by the same rst, so no stale data_ok is expected.

Decomposition:
- New entries in lib/defines.vh:
  - `IC_TO_ID_WD (97).
  - `IF_IDLE/`IF_REQ/`IF_WAIT state encodings (2-bit).
  - `ExcAdelBit (16).
  - Reuse existing `PC_TO_IT_WD, `StallBus, `NoStop.
- One sub-module, if_skid_buf: single-entry {pc, inst, excepttype} holding register with full flag, load/drain/clear inputs. The controller FSM and output register stay in if_fetch_ctrl.

Test Plan:
- Reset then pc=0xbfc00000, ce=1; addr_ok in the 1st REQ cycle, data_ok 2 cycles later with rdata=0x3c080001 -> inst_req high exactly 1 cycle, stallreq_if high until the data_ok cycle, next edge ic_to_id_bus = {1, 0, 0xbfc00000, 0x3c080001}.
- Flush in the WAIT cycle before data_ok=1 (rdata=0xdeadbeef) -> data dropped, valid stays 0, cancel cleared, FSM back in IDLE next cycle.
- pc=0xbfc00002 (excepttype=0x00010000) -> inst_req never asserted; next edge valid=1, inst=0, excepttype=0x00010000.
- stall[1]=1 for 3 cycles spanning data_ok (rdata=0x24020005) -> ic_to_id_bus unchanged while stalled, no new inst_req; the word appears on the first edge after stall[1]=0.
- addr_ok withheld 4 cycles -> inst_addr stable and inst_req high throughout; a flush in cycle 2 does not drop inst_req, and the later data is discarded.
- rst=0 asserted mid-WAIT (async, between edges) -> all outputs 0 immediately; after release the FSM is IDLE and refetches the current pc.
